// File: rtl/serial_byte_receiver_if.sv
// Serial-in / parallel-out bus for serial_byte_receiver. It carries the serial input,
// the valid/ready word output and the status flags.
interface serial_byte_receiver_if #(
   parameter int WIDTH = 8
);
   logic             sin;
   logic             sin_valid;
   logic             start;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             dout_ready;
   logic             busy;
   logic             frame_err;
   logic             overrun;
   logic             clr_ovr;

   // The master drives bits in and consumes words. The slave is the receiver.
   modport master (
      output sin, sin_valid, start, dout_ready, clr_ovr,
      input  dout, dout_valid, busy, frame_err, overrun
   );

   modport slave (
      input  sin, sin_valid, start, dout_ready, clr_ovr,
      output dout, dout_valid, busy, frame_err, overrun
   );
endinterface

// File: rtl/serial_byte_receiver.sv
// Reassembles an MSB-first serial stream, framed by a start strobe, into WIDTH-bit words.
// Words are held in a one-deep valid/ready register. Resync and overrun are flagged.
module serial_byte_receiver #(
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   serial_byte_receiver_if.slave   bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] next_word;
   logic             word_done;

   always_comb begin
      next_word = {shreg[WIDTH-2:0], bus.sin};
      word_done = bus.sin_valid && !bus.start && (state == SHIFT) &&
                  (cnt == CNT_W'(WIDTH - 1));
   end

   // NOTE: sequential state uses non-blocking assignments only. Every register, including
   // the shift register, is reset, so a partial word can never leak out after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         shreg          <= '0;
         cnt            <= '0;
         bus.dout       <= '0;
         bus.dout_valid <= 1'b0;
         bus.busy       <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         bus.frame_err <= 1'b0;

         if (bus.sin_valid) begin
            case (state)
               IDLE: begin
                  if (bus.start) begin
                     shreg    <= next_word;
                     cnt      <= CNT_W'(1);
                     state    <= SHIFT;
                     bus.busy <= 1'b1;
                  end
               end
               SHIFT: begin
                  if (bus.start) begin
                     // A start strobe in mid-word drops the partial word and begins a new one.
                     shreg         <= next_word;
                     cnt           <= CNT_W'(1);
                     bus.frame_err <= 1'b1;
                  end else if (word_done) begin
                     shreg    <= next_word;
                     cnt      <= '0;
                     state    <= IDLE;
                     bus.busy <= 1'b0;
                  end else begin
                     shreg <= next_word;
                     cnt   <= cnt + CNT_W'(1);
                  end
               end
               default: begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
            endcase
         end

         if (bus.clr_ovr)
            bus.overrun <= 1'b0;

         // A new overrun is assigned after the clear, so setting the flag wins over clearing it.
         if (word_done) begin
            if (!bus.dout_valid || bus.dout_ready) begin
               bus.dout       <= next_word;
               bus.dout_valid <= 1'b1;
            end else begin
               bus.overrun <= 1'b1;
            end
         end else if (bus.dout_valid && bus.dout_ready) begin
            bus.dout_valid <= 1'b0;
         end
      end
   end

endmodule

// File: doc/serial_byte_receiver.md
Name: serial_byte_receiver

Overview:
- Receive-side counterpart of the team's 8-bit shift-left serial-out register. It reassembles the MSB-first serial bit stream that register emits into parallel words.
- Words are framed by a start strobe on the first (MSB) bit.
- Completed words are presented through a one-deep valid/ready holding register to downstream parallel logic.
- Framing errors and overrun are flagged.

Parameters:
- WIDTH, 8, bits per word. Legal range is WIDTH >= 2.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- sin  input  1  serial data bit, MSB first.
- sin_valid  input  1  sin carries a valid bit this cycle.
- start  input  1  qualified by sin_valid; marks the current bit as bit WIDTH-1 (first bit) of a new word.
- dout  output  WIDTH  assembled word.
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  downstream accepts dout this cycle.
- busy  output  1  a word is partially received (state SHIFT).
- frame_err  output  1  one-cycle pulse: start arrived mid-word.
- overrun  output  1  sticky: a completed word was dropped.
- clr_ovr  input  1  synchronous clear of overrun.

Behaviour:
- Reset (rst_n low, asynchronous):
  - shreg=0, cnt=0, state=IDLE.
  - dout=0, dout_valid=0, busy=0, frame_err=0, overrun=0.
  - A partial word is discarded; nothing is emitted after reset release until a new start arrives.
- Internal state:
  - Shift register shreg[WIDTH-1:0].
  - Bit counter cnt, width $clog2(WIDTH+1).
  - FSM with states IDLE and SHIFT; busy = (state==SHIFT).
- Shift rule: shreg <= {shreg[WIDTH-2:0], sin}, i.e. shift left with the new bit in the LSB. The first bit received lands in dout[WIDTH-1].
- sin_valid low: nothing happens. shreg, cnt and state hold; gaps of any length are legal.
- IDLE state:
  - sin_valid && start: shift, cnt=1, go to SHIFT.
  - sin_valid && !start: the bit is ignored and the state stays IDLE.
- SHIFT state:
  - sin_valid && !start: shift and increment cnt.
  - When the accepted bit is the WIDTH-th (cnt==WIDTH-1 before the edge), the word completes. On that same edge the completed value {shreg[WIDTH-2:0],sin} is offered to the output register, cnt=0, and the state goes to IDLE.
  - Latency: dout/dout_valid are visible the cycle after the last bit's edge.
  - sin_valid && start (resync): the partial word is discarded and this bit is treated as the first bit of a new word (cnt=1, stay in SHIFT). frame_err pulses high for exactly one cycle.
- Output register, on a word-completion edge:
  - If !dout_valid, or (dout_valid && dout_ready): dout <= new word and dout_valid <= 1. Consuming the old word and loading the new one in the same cycle does not count as overrun.
  - If dout_valid && !dout_ready: the new word is dropped, dout is unchanged, and overrun <= 1.
- Output register, with no completion this cycle: dout_valid && dout_ready clears dout_valid. dout keeps its last value.
- dout changes only when a word is loaded.
- overrun:
  - Cleared by clr_ovr.
  - If clr_ovr and a new overrun occur in the same cycle, set wins.
- dout_ready while !dout_valid: no effect.

Test Plan:
- Basic word: reset, then start=1 with bits 1,0,1,1,0,0,1,0 on consecutive sin_valid cycles, dout_ready=1 -> dout=8'hB2 with dout_valid high for one cycle. busy is high from after the first bit until the last-bit edge; overrun=0.
- Gaps: same word with sin_valid low for 3 cycles between each bit -> dout=8'hB2, and it appears exactly one cycle after the 8th valid bit.
- Back-pressure/overrun: dout_ready=0, send 8'h5A then 8'hC3 -> dout stays 8'h5A, overrun=1. After clr_ovr pulse -> overrun=0. With dout_ready=1 while 8'h3C completes and 8'h5A is pending -> dout=8'h3C, dout_valid stays 1, overrun stays 0.
- Resync: send 4 bits of a word, then start with the 8 bits of 8'hE1 -> one frame_err pulse on the resync cycle; dout=8'hE1; the partial bits are never emitted.
- Pre-start noise: 5 valid bits with start=0 while in IDLE, then word 8'h81 -> only 8'h81 appears.
- Reset mid-word: assert rst_n low after 5 bits, release, send 8'hFF -> all outputs are 0 during reset; the next output is 8'hFF with no stale bits.
